imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Byte-stream boot loader: writer side of the byte-wide instruction memory.
//  Accepts a framed byte stream (sync, 16-bit length, payload) over valid/ready.
//  Writes payload little-endian from byte address 0 through a byte write port.
//  Holds the core in reset until a complete, valid image is loaded.
// PARAMETERS
//  MEM_BYTES  1024  instruction memory size in bytes; legal image length 1..MEM_BYTES
//  ADDR_W     10    width of mem_addr; must equal clog2(MEM_BYTES)
//  SYNC_BYTE  8'hA5 frame start marker
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst        in   1       asynchronous, active-high reset
//  rx_data    in   8       incoming stream byte
//  rx_valid   in   1       rx_data valid
//  rx_ready   out  1       loader can accept; byte transfers when rx_valid & rx_ready
//  mem_we     out  1       byte write strobe to instruction memory
//  mem_addr   out  ADDR_W  byte write address
//  mem_wdata  out  8       byte write data
//  cpu_hold   out  1       1 = keep core in reset / stalled
//  done       out  1       image loaded successfully (level)
//  error      out  1       frame rejected (level)
// BEHAVIOUR
//  Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1,
//   done=0, error=0; state=IDLE, byte counter=0. rx_ready=1 from first cycle after reset.
//  States: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR. rx_ready=1 in every state.
//  IDLE: byte==SYNC_BYTE -> LEN_LO; any other byte is consumed and dropped.
//  LEN_LO/LEN_HI: capture length low then high byte. After LEN_HI:
//   len==0 or len>MEM_BYTES -> ERR; else -> DATA, counter=0.
//  DATA: each accepted byte -> next cycle mem_we=1 for exactly one cycle,
//   mem_addr=counter, mem_wdata=byte (1-cycle registered latency); counter++.
//   mem_we=0 in every cycle without a DATA handshake. Back-to-back bytes give
//   back-to-back writes. After byte len-1 -> CHK (macro on) or DONE (macro off).
//  No address wrap: counter never exceeds len-1 <= MEM_BYTES-1.
//  DONE: done=1, cpu_hold=0 from the cycle after entry; last mem_we coincides
//   with or precedes this cycle.
//  ERR: error=1, cpu_hold=1.
//  DONE/ERR: a SYNC_BYTE restarts the frame (-> LEN_LO): done and error clear and
//   cpu_hold=1 on the next cycle; other bytes are dropped.
//  Partial image never releases the core: cpu_hold stays 1 until DONE.
//  rx_valid deasserted mid-frame: state holds indefinitely (no timeout).
//  rst mid-frame: immediate return to reset values; written bytes remain in memory.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: running XOR of payload bytes. CHK consumes one
//   trailing byte; equal -> DONE, else -> ERR. Checksum register clears on
//   entering LEN_LO.
//  Not defined: no CHK state, no checksum logic; last payload byte -> DONE.
// STRUCTURE
//  Package imem_loader_pkg: loader_state_t enum, SYNC_BYTE default, MEM_BYTES default.
//  Single module, no sub-module; FSM, length/counter and write register are inline.
// TESTING
//  1) A5,04,00,13,00,00,00 (macro off) -> 4 writes addr 0..3 data 13,00,00,00;
//     done=1, cpu_hold=0 the cycle after the last accepted byte.
//  2) Same frame + checksum 13 (macro on) -> done; checksum 12 -> error=1,
//     cpu_hold=1, 4 writes still occur.
//  3) Length 0 and length 1025 (01,04) -> error=1, no mem_we; then A5 -> error clears.
//  4) Bytes 00,FF,A5,01,00,7F with gaps on rx_valid -> leading 00,FF dropped;
//     one write addr 0 data 7F; done.
//  5) rst asserted during DATA after 2 of 8 bytes -> outputs at reset values
//     asynchronously; new frame loads from addr 0.
//  6) Full 1024-byte frame, rx_valid held high -> 1024 consecutive mem_we cycles,
//     last addr 1023, no wrap.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM states and default frame/memory constants
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int         DEF_MEM_BYTES = 1024;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader into byte-wide imem; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         MEM_BYTES = DEF_MEM_BYTES,
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    loader_state_t     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rdy_q;
    logic              fire, last, bad_len;
    logic [15:0]       full_len;

    assign fire     = rx_valid & rdy_q;
    assign full_len = {rx_data, len_q[7:0]};
    assign bad_len  = (full_len == 16'd0) || (full_len > 16'(MEM_BYTES));
    assign last     = 16'(cnt_q) == len_q - 16'd1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdy_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end

    always_comb begin
        state_d = state_q;
        if (fire)
            case (state_q)
                S_IDLE, S_DONE, S_ERR: state_d = rx_data == SYNC_BYTE ? S_LEN_LO : state_q;
                S_LEN_LO:              state_d = S_LEN_HI;
                S_LEN_HI:              state_d = bad_len ? S_ERR : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_DATA:                state_d = last ? S_CHK : S_DATA;
                S_CHK:                 state_d = rx_data == chk_q ? S_DONE : S_ERR;
`else
                S_DATA:                state_d = last ? S_DONE : S_DATA;
`endif
                default:               state_d = S_IDLE;
            endcase
    end

    // Counter saturates on the last byte so it never exceeds len-1.
    always_comb begin
        we_d    = fire && state_q == S_DATA;
        addr_d  = we_d ? cnt_q : addr_q;
        wdata_d = we_d ? rx_data : wdata_q;
        len_d   = fire && state_q == S_LEN_LO ? {8'h00, rx_data} :
                  fire && state_q == S_LEN_HI ? full_len : len_q;
        cnt_d   = fire && state_q == S_LEN_HI ? '0 :
                  we_d && !last ? cnt_q + 1'b1 : cnt_q;
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_comb begin
        chk_d = (state_d == S_LEN_LO && state_q != S_LEN_LO) ? 8'h00 :
                we_d ? chk_q ^ rx_data : chk_q;
    end
`endif

    always_comb begin
        done     = state_q == S_DONE;
        error    = state_q == S_ERR;
        cpu_hold = state_q != S_DONE;
    end

    assign rx_ready  = rdy_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
